// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and helpers for the pipeline hazard controller
package pipe_pkg;
  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10} fwd_sel_t;
  // The younger producer (now in E, heading to M) wins over the older one
  function automatic fwd_sel_t fwd_pick(input logic hit_e, input logic hit_m);
    return hit_e ? FWD_M : (hit_m ? FWD_W : FWD_RF);
  endfunction
endpackage

// File: rtl/perf_sat_counter.sv
// perf_sat_counter: saturating event counter with synchronous active-low clear
module perf_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr_n_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign cnt_d = (en_i && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= clr_n_i ? cnt_d : '0;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use stall, branch flush, memory freeze and Execute forwarding control
module pipeline_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_d,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic              use_rs1_d,
  input  logic              use_rs2_d,
  input  logic [REG_AW-1:0] rd_d,
  input  logic              reg_write_d,
  input  logic              load_d,
  input  logic              pcsrc_e,
  input  logic              mem_ready_m,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_d,
  output logic              flush_e,
  output logic              freeze,
  output logic [1:0]        fwd_a_e,
  output logic [1:0]        fwd_b_e,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              we;
    logic              load;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
  } stage_tag_t;
  stage_tag_t e_q, m_q, w_q, e_d;
  fwd_sel_t fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;
  logic branch, load_use;
  function automatic logic live(input logic [REG_AW-1:0] r);
    return !ZERO_REG || r != '0;
  endfunction
  function automatic logic hit_e(input logic [REG_AW-1:0] r);
    return e_q.valid && e_q.we && e_q.rd == r && live(r);
  endfunction
  function automatic logic hit_m(input logic [REG_AW-1:0] r);
    return m_q.valid && m_q.we && m_q.rd == r && live(r);
  endfunction
  function automatic fwd_sel_t fwd_sel(input logic used, input logic [REG_AW-1:0] r);
    return used ? fwd_pick(hit_e(r), hit_m(r)) : FWD_RF;
  endfunction
  assign branch   = pcsrc_e & e_q.valid;
  assign load_use = valid_d & e_q.load & ((use_rs1_d & hit_e(rs1_d)) | (use_rs2_d & hit_e(rs2_d)));
  assign freeze   = ~mem_ready_m;
  // A taken branch squashes Decode, so it overrides the load-use stall
  assign stall_f  = freeze | (load_use & ~branch);
  assign stall_d  = stall_f;
  assign flush_d  = ~freeze & branch;
  assign flush_e  = ~freeze & (branch | load_use);
  assign e_d      = flush_e ? stage_tag_t'('0) :
                    '{valid: valid_d, rd: rd_d, we: reg_write_d, load: load_d, rs1: rs1_d, rs2: rs2_d};
  assign fwd_a_d  = flush_e ? FWD_RF : fwd_sel(use_rs1_d, rs1_d);
  assign fwd_b_d  = flush_e ? FWD_RF : fwd_sel(use_rs2_d, rs2_d);
  always_ff @(posedge clk)
    if (!reset) begin
      e_q     <= '0;
      m_q     <= '0;
      w_q     <= '0;
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else if (mem_ready_m) begin
      w_q     <= m_q;
      m_q     <= e_q;
      e_q     <= e_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  assign fwd_a_e = fwd_a_q;
  assign fwd_b_e = fwd_b_q;
  perf_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk), .clr_n_i(reset), .en_i(stall_d), .cnt_o(stall_cnt)
  );
  perf_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk(clk), .clr_n_i(reset), .en_i(flush_d), .cnt_o(flush_cnt)
  );
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed checks of stalls, flushes, freeze, forwarding and counters
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0, reset, valid_d, use_rs1_d, use_rs2_d, reg_write_d, load_d, pcsrc_e, mem_ready_m;
  logic [4:0] rs1_d, rs2_d, rd_d;
  logic stall_f, stall_d, flush_d, flush_e, freeze;
  logic [1:0] fwd_a_e, fwd_b_e;
  logic [3:0] stall_cnt, flush_cnt;
  logic z_stall_f, z_stall_d, z_flush_d, z_flush_e, z_freeze;
  logic [1:0] z_fwd_a_e, z_fwd_b_e;
  logic [15:0] z_stall_cnt, z_flush_cnt;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  pipeline_hazard_ctrl #(.REG_AW(5), .ZERO_REG(1'b1), .CNT_W(4)) u0 (
    .clk(clk), .reset(reset), .valid_d(valid_d), .rs1_d(rs1_d), .rs2_d(rs2_d),
    .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d), .rd_d(rd_d), .reg_write_d(reg_write_d),
    .load_d(load_d), .pcsrc_e(pcsrc_e), .mem_ready_m(mem_ready_m), .stall_f(stall_f),
    .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e), .freeze(freeze),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  pipeline_hazard_ctrl #(.REG_AW(5), .ZERO_REG(1'b0), .CNT_W(16)) u1 (
    .clk(clk), .reset(reset), .valid_d(valid_d), .rs1_d(rs1_d), .rs2_d(rs2_d),
    .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d), .rd_d(rd_d), .reg_write_d(reg_write_d),
    .load_d(load_d), .pcsrc_e(pcsrc_e), .mem_ready_m(mem_ready_m), .stall_f(z_stall_f),
    .stall_d(z_stall_d), .flush_d(z_flush_d), .flush_e(z_flush_e), .freeze(z_freeze),
    .fwd_a_e(z_fwd_a_e), .fwd_b_e(z_fwd_b_e), .stall_cnt(z_stall_cnt), .flush_cnt(z_flush_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask
  task automatic dec(input logic v, input logic [4:0] a, input logic [4:0] b, input logic ua,
                     input logic ub, input logic [4:0] rd, input logic we, input logic ld);
    valid_d = v; rs1_d = a; rs2_d = b; use_rs1_d = ua; use_rs2_d = ub;
    rd_d = rd; reg_write_d = we; load_d = ld;
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
  initial begin
    reset = 1'b0; mem_ready_m = 1'b1; pcsrc_e = 1'b0;
    dec(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(); cyc();
    chk("rst_stall_f", stall_f, 0); chk("rst_stall_d", stall_d, 0);
    chk("rst_flush_d", flush_d, 0); chk("rst_flush_e", flush_e, 0);
    chk("rst_freeze", freeze, 0); chk("rst_fwd_a", fwd_a_e, 0); chk("rst_fwd_b", fwd_b_e, 0);
    chk("rst_stall_cnt", stall_cnt, 0); chk("rst_flush_cnt", flush_cnt, 0);
    chk("rst_z_fwd_a", z_fwd_a_e, 0);
    reset = 1'b1;
    // add r3,r1,r2 then sub r7,r3,r4 then and r9,r7,r3
    cyc(); dec(1, 1, 2, 1, 1, 3, 1, 0);
    chk("t1_add_nostall", stall_d, 0);
    cyc(); dec(1, 3, 4, 1, 1, 7, 1, 0);
    chk("t1_sub_nostall", stall_d, 0); chk("t1_sub_noflush", flush_e, 0);
    chk("t1_add_fwd_a", fwd_a_e, 0);
    cyc(); dec(1, 7, 3, 1, 1, 9, 1, 0);
    chk("t1_sub_fwd_a", fwd_a_e, 2); chk("t1_sub_fwd_b", fwd_b_e, 0);
    // lw r5,0(r1): consumer 'and' now in E with sub in M, add in W
    cyc(); dec(1, 1, 0, 1, 0, 5, 1, 1);
    chk("t1_and_fwd_a", fwd_a_e, 2); chk("t1_and_fwd_b", fwd_b_e, 1);
    chk("t2_lw_nostall", stall_d, 0);
    cyc(); dec(1, 5, 1, 1, 1, 6, 1, 0);
    chk("t2_lu_stall_f", stall_f, 1); chk("t2_lu_stall_d", stall_d, 1);
    chk("t2_lu_flush_e", flush_e, 1); chk("t2_lu_flush_d", flush_d, 0);
    chk("t2_lu_cnt_pre", stall_cnt, 0);
    cyc();
    chk("t2_bubble_stall_d", stall_d, 0); chk("t2_bubble_flush_e", flush_e, 0);
    chk("t2_stall_cnt", stall_cnt, 1); chk("t2_bubble_fwd_a", fwd_a_e, 0);
    cyc(); dec(1, 2, 0, 1, 0, 10, 1, 1);
    chk("t2_add_fwd_a", fwd_a_e, 1); chk("t2_add_fwd_b", fwd_b_e, 0);
    chk("t2_stall_cnt_hold", stall_cnt, 1);
    // taken branch coinciding with a load-use on lw r10
    cyc(); pcsrc_e = 1'b1; dec(1, 10, 0, 1, 0, 11, 1, 0);
    chk("t3_flush_d", flush_d, 1); chk("t3_flush_e", flush_e, 1);
    chk("t3_stall_d", stall_d, 0); chk("t3_stall_f", stall_f, 0);
    cyc(); pcsrc_e = 1'b0; dec(1, 1, 2, 1, 1, 0, 0, 0);
    chk("t3_flush_cnt", flush_cnt, 1); chk("t3_stall_cnt", stall_cnt, 1);
    chk("t3_after_flush_d", flush_d, 0); chk("t3_after_fwd_a", fwd_a_e, 0);
    // beq in E taken while memory waits three cycles
    cyc(); pcsrc_e = 1'b1; mem_ready_m = 1'b0; dec(1, 1, 0, 1, 0, 12, 1, 0);
    for (int i = 0; i < 3; i++) begin
      chk("t4_freeze", freeze, 1); chk("t4_no_flush_d", flush_d, 0);
      chk("t4_no_flush_e", flush_e, 0); chk("t4_stall_d", stall_d, 1);
      chk("t4_stall_cnt", stall_cnt, 1 + i);
      cyc();
    end
    mem_ready_m = 1'b1; #1;
    chk("t4_release_flush_d", flush_d, 1); chk("t4_release_flush_e", flush_e, 1);
    chk("t4_release_freeze", freeze, 0); chk("t4_release_stall_cnt", stall_cnt, 4);
    chk("t4_release_flush_cnt", flush_cnt, 1);
    // add r0,r1,r2 then add r13,r0,r0
    cyc(); pcsrc_e = 1'b0; dec(1, 1, 2, 1, 1, 0, 1, 0);
    chk("t4_flush_cnt", flush_cnt, 2); chk("t4_stall_cnt_final", stall_cnt, 4);
    chk("t4_z_stall_cnt", z_stall_cnt, 4);
    cyc(); dec(1, 0, 0, 1, 1, 13, 1, 0);
    chk("t5_r0_nostall", stall_d, 0); chk("t5_z_r0_nostall", z_stall_d, 0);
    cyc(); dec(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t5_r0_fwd_a", fwd_a_e, 0); chk("t5_r0_fwd_b", fwd_b_e, 0);
    chk("t5_z_r0_fwd_a", z_fwd_a_e, 2); chk("t5_z_r0_fwd_b", z_fwd_b_e, 2);
    // twenty frozen cycles saturate the 4-bit counter
    mem_ready_m = 1'b0;
    for (int i = 0; i < 20; i++) cyc();
    mem_ready_m = 1'b1; #1;
    chk("t6_stall_cnt_sat", stall_cnt, 15); chk("t6_z_stall_cnt", z_stall_cnt, 24);
    cyc(); dec(1, 1, 0, 1, 0, 5, 1, 1);
    cyc(); dec(1, 5, 1, 1, 1, 6, 1, 0);
    chk("t6_lu_stall_d", stall_d, 1); chk("t6_stall_cnt_held", stall_cnt, 15);
    reset = 1'b0; pcsrc_e = 1'b1;
    cyc();
    chk("t6_rst_stall_f", stall_f, 0); chk("t6_rst_stall_d", stall_d, 0);
    chk("t6_rst_flush_d", flush_d, 0); chk("t6_rst_flush_e", flush_e, 0);
    chk("t6_rst_freeze", freeze, 0); chk("t6_rst_fwd_a", fwd_a_e, 0);
    chk("t6_rst_fwd_b", fwd_b_e, 0); chk("t6_rst_stall_cnt", stall_cnt, 0);
    chk("t6_rst_flush_cnt", flush_cnt, 0); chk("t6_rst_z_stall_cnt", z_stall_cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
